cadr_clk_seq: RTL and testbench
===============================

# cadr_clk_seq

Machine-clock sequencer for the CADR processor. It decides when the register-level flops advance by generating a one-CLK-wide machine clock enable (MCLK_EN) and write pulse (WP). It supports run, stop, single-step, error halt, slow-cycle stretch and memory wait. It sits between the debug/console interface and every clock-enabled flop in the datapath.

## Interface
- STRETCH_CYC, 2: extra CLK cycles inserted in a machine cycle when SLOW is sampled high; range 1..15.
- CNT_W, 16: width of the step counter.
- CLK  in  1  system clock; all state changes on posedge.
- R_N  in  1  asynchronous, active-low reset.
- RUN_REQ  in  1  one-CLK pulse: start free-running.
- STOP_REQ  in  1  one-CLK pulse: halt at the end of the current machine cycle.
- STEP_REQ  in  1  one-CLK pulse: execute exactly one machine cycle.
- ERR  in  1  level: error condition from the datapath (parity, etc.).
- SLOW  in  1  level: sampled in PH0; lengthens the current cycle.
- MEM_WAIT  in  1  level: holds the cycle in PH1 while high.
- CNT_LOAD  in  1  one-CLK pulse: load the step counter.
- CNT_VAL  in  CNT_W  step-counter load value.
- MCLK_EN  out  1  machine clock enable.
- WP  out  1  write pulse; coincident with MCLK_EN.
- RUNNING  out  1  high in any state other than HALT.
- HALTED  out  1  equals ~RUNNING.
- ERR_HALT  out  1  sticky: the last halt was caused by ERR.
- STEP_CNT  out  CNT_W  current step-counter value.

## Operation
- States: HALT, PH0, STR, PH1.
- Pending flags: single (step mode) and stop_pend.
- HALT:
  - If STEP_REQ and ERR=0: go to PH0, set single=1, clear ERR_HALT.
  - Else if RUN_REQ, STOP_REQ=0 and ERR=0: go to PH0, set single=0, clear ERR_HALT.
  - STEP beats RUN when both arrive together. STOP in the same cycle as RUN cancels the RUN.
  - While ERR=1, every request is ignored.
- PH0: go to STR if SLOW=1, otherwise PH1. STR loads its counter with STRETCH_CYC-1.
- STR: count down; go to PH1 after STRETCH_CYC cycles.
- PH1:
  - MEM_WAIT=1: stay in PH1; MCLK_EN=0.
  - MEM_WAIT=0: MCLK_EN=WP=1 for this cycle. Next state is HALT if single, stop_pend, ERR, or a counter expiry (see Configuration); otherwise PH0.
  - If ERR causes the halt, set ERR_HALT=1.
  - On entering HALT, clear stop_pend and single.
- STOP_REQ or ERR that arrives while running never truncates a cycle. The in-progress machine cycle always completes, including its MCLK_EN.
- RUN_REQ and STEP_REQ received while running are ignored. STOP_REQ received while halted is ignored.
- MCLK_EN and WP are the only Mealy outputs: (state==PH1 && !MEM_WAIT). All other outputs are registered.

## Timing
- Reset, asynchronous and effective immediately, including mid-cycle. After reset: state=HALT, MCLK_EN=0, WP=0, RUNNING=0, HALTED=1, ERR_HALT=0, STEP_CNT=0, single=0, stop_pend=0.
- Latency: a request pulse at edge n puts the block in PH0 after edge n. With no SLOW and no MEM_WAIT, MCLK_EN is high during the cycle after edge n+1.
- Minimum machine cycle is 2 CLK. With SLOW it is 2+STRETCH_CYC CLK. Each CLK with MEM_WAIT high in PH1 adds one CLK.
- Back-to-back running: MCLK_EN is high 1 CLK out of every 2.
- STOP_REQ in PH0 or STR: the current cycle's MCLK_EN fires, then HALT.
- STOP_REQ in the same CLK as a PH1 completion: HALT immediately after that cycle.

## Configuration
- CADR_STEP_CNT_EN defined:
  - CNT_LOAD loads CNT_VAL into STEP_CNT. Loading has priority over decrementing in the same CLK.
  - Each MCLK_EN with STEP_CNT≠0 decrements STEP_CNT.
  - The decrement from 1 to 0 forces HALT at the end of that cycle, with ERR_HALT=0.
  - STEP_CNT=0 means unlimited.
- CADR_STEP_CNT_EN undefined:
  - The ports are still present. CNT_LOAD and CNT_VAL are ignored and STEP_CNT is tied to 0.
  - No counter logic is built.

## Test plan
- Reset, then STEP_REQ pulse → exactly one MCLK_EN/WP pulse, 2 CLK after the request edge. Then HALTED=1 and RUNNING=0.
- RUN_REQ, then 10 CLK later STOP_REQ → MCLK_EN pulses every 2nd CLK. The cycle in flight completes, then HALTED=1 with no truncated pulse.
- Running, SLOW=1 with STRETCH_CYC=2 → 4 CLK between MCLK_EN pulses. MEM_WAIT high for 3 CLK in PH1 → that cycle lengthens by 3 and MCLK_EN fires on the first CLK with MEM_WAIT=0.
- ERR raised mid-run → the current cycle completes, then HALT with ERR_HALT=1. RUN_REQ while ERR=1 is ignored. After ERR drops, RUN_REQ restarts and clears ERR_HALT.
- RUN_REQ and STEP_REQ in the same CLK → single step only. RUN_REQ and STOP_REQ in the same CLK while halted → stays halted.
- With CADR_STEP_CNT_EN: load 5, then RUN_REQ → exactly 5 MCLK_EN pulses, then HALT with STEP_CNT=0. Assert R_N low mid-cycle → MCLK_EN drops to 0 at once and all reset values appear.

Source files
------------

// File: rtl/cadr_clk_seq_if.sv
// Console/datapath bundle for the CADR machine-clock sequencer.
// The master side is the debug console; the slave side is cadr_clk_seq.
interface cadr_clk_seq_if #(
    parameter int CNT_W = 16
);
    logic             run_req;
    logic             stop_req;
    logic             step_req;
    logic             err;
    logic             slow;
    logic             mem_wait;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             mclk_en;
    logic             wp;
    logic             running;
    logic             halted;
    logic             err_halt;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output run_req, stop_req, step_req, err, slow, mem_wait, cnt_load, cnt_val,
        input  mclk_en, wp, running, halted, err_halt, step_cnt
    );

    modport slave (
        input  run_req, stop_req, step_req, err, slow, mem_wait, cnt_load, cnt_val,
        output mclk_en, wp, running, halted, err_halt, step_cnt
    );
endinterface

// File: rtl/cadr_clk_seq.sv
// CADR machine-clock sequencer: run/stop/step/error halt, slow stretch and memory wait.
// Optional step counter built only when CADR_STEP_CNT_EN is defined.
//
// state | meaning
// HALT  | machine stopped, waiting for RUN_REQ or STEP_REQ
// PH0   | first phase of a machine cycle, SLOW sampled here
// STR   | slow-cycle stretch, STRETCH_CYC clocks
// PH1   | final phase; MCLK_EN/WP fire unless MEM_WAIT holds it
module cadr_clk_seq #(
    parameter int STRETCH_CYC = 2,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         r_n,
    cadr_clk_seq_if.slave bus
);
    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] PH0  = 2'd1;
    localparam logic [1:0] STR  = 2'd2;
    localparam logic [1:0] PH1  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             single;
    logic             stop_pend;
    logic [3:0]       str_cnt;
    logic             running;
    logic             halted;
    logic             err_halt;
    logic             mclk_en;
    logic             halt_now;
    logic             cnt_expire;
    logic [CNT_W-1:0] step_cnt;

    assign mclk_en = (state == PH1) && !bus.mem_wait;

    always_comb begin
        state_nxt = state;
        halt_now  = 1'b0;
        case (state)
            HALT: begin
                if (bus.step_req && !bus.err)
                    state_nxt = PH0;
                else if (bus.run_req && !bus.stop_req && !bus.err)
                    state_nxt = PH0;
            end
            PH0: state_nxt = bus.slow ? STR : PH1;
            STR: begin
                if (str_cnt == 4'd0)
                    state_nxt = PH1;
            end
            PH1: begin
                if (!bus.mem_wait) begin
                    // A stop arriving on the completing edge still halts right after this cycle.
                    halt_now  = single || stop_pend || bus.stop_req || bus.err || cnt_expire;
                    state_nxt = halt_now ? HALT : PH0;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state     <= HALT;
            single    <= 1'b0;
            stop_pend <= 1'b0;
            str_cnt   <= 4'd0;
            running   <= 1'b0;
            halted    <= 1'b1;
            err_halt  <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt != HALT);
            halted  <= (state_nxt == HALT);
            case (state)
                HALT: begin
                    if (state_nxt == PH0) begin
                        single    <= bus.step_req;
                        stop_pend <= 1'b0;
                        err_halt  <= 1'b0;
                    end
                end
                PH0: begin
                    if (bus.slow)
                        str_cnt <= 4'(STRETCH_CYC - 1);
                end
                STR: begin
                    if (str_cnt != 4'd0)
                        str_cnt <= str_cnt - 4'd1;
                end
                default: ;
            endcase
            if ((state != HALT) && bus.stop_req)
                stop_pend <= 1'b1;
            if (halt_now) begin
                stop_pend <= 1'b0;
                single    <= 1'b0;
                err_halt  <= bus.err;
            end
        end
    end

`ifdef CADR_STEP_CNT_EN
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)
            step_cnt <= '0;
        else if (bus.cnt_load)
            step_cnt <= bus.cnt_val;
        else if (mclk_en && (step_cnt != '0))
            step_cnt <= step_cnt - 1'b1;
    end

    // A same-cycle load wins, so no decrement and no expiry then.
    assign cnt_expire = mclk_en && !bus.cnt_load && (step_cnt == CNT_W'(1));
`else
    logic unused_cnt;
    assign unused_cnt = ^{bus.cnt_load, bus.cnt_val};
    assign step_cnt   = '0;
    assign cnt_expire = 1'b0;
`endif

    assign bus.mclk_en  = mclk_en;
    assign bus.wp       = mclk_en;
    assign bus.running  = running;
    assign bus.halted   = halted;
    assign bus.err_halt = err_halt;
    assign bus.step_cnt = step_cnt;
endmodule

// File: tb/tb_cadr_clk_seq.sv
// Directed self-checking bench for cadr_clk_seq (default STRETCH_CYC=2, CNT_W=16).
module tb_cadr_clk_seq;
    logic clk;
    logic r_n;
    int   n_chk;
    int   n_fail;
    int   pulses;

    cadr_clk_seq_if #(.CNT_W(16)) bus ();

    cadr_clk_seq #(.STRETCH_CYC(2), .CNT_W(16)) dut (
        .clk (clk),
        .r_n (r_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        r_n = 1'b0;
        bus.run_req = 0; bus.stop_req = 0; bus.step_req = 0;
        bus.err = 0; bus.slow = 0; bus.mem_wait = 0;
        bus.cnt_load = 0; bus.cnt_val = '0;
        #12;
        chk("rst_mclk", bus.mclk_en, 0);
        chk("rst_wp", bus.wp, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_halted", bus.halted, 1);
        chk("rst_err_halt", bus.err_halt, 0);
        chk("rst_step_cnt", bus.step_cnt, 0);
        r_n = 1'b1;
        cyc();

        // single step: pulse in the cycle after edge n+1, then halt
        bus.step_req = 1; cyc(); bus.step_req = 0;
        chk("step_ph0_mclk", bus.mclk_en, 0);
        chk("step_ph0_running", bus.running, 1);
        cyc();
        chk("step_ph1_mclk", bus.mclk_en, 1);
        chk("step_ph1_wp", bus.wp, 1);
        cyc();
        chk("step_done_mclk", bus.mclk_en, 0);
        chk("step_done_halted", bus.halted, 1);
        chk("step_done_running", bus.running, 0);
        cyc();

        // free run, stop arriving in PH0
        bus.run_req = 1; cyc(); bus.run_req = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("run_mclk_%0d", i), bus.mclk_en, (i % 2 == 1) ? 1 : 0);
            cyc();
        end
        bus.stop_req = 1; cyc(); bus.stop_req = 0;
        chk("stop_ph0_last_mclk", bus.mclk_en, 1);
        chk("stop_ph0_still_running", bus.running, 1);
        cyc();
        chk("stop_ph0_halted", bus.halted, 1);
        chk("stop_ph0_mclk", bus.mclk_en, 0);

        // stop on the completing PH1 edge
        bus.run_req = 1; cyc(); bus.run_req = 0;
        cyc();
        chk("stop_ph1_mclk", bus.mclk_en, 1);
        bus.stop_req = 1; cyc(); bus.stop_req = 0;
        chk("stop_ph1_halted", bus.halted, 1);
        chk("stop_ph1_mclk_after", bus.mclk_en, 0);
        cyc();

        // slow cycles: 4 CLK between pulses, then a 3-CLK memory wait
        bus.slow = 1;
        bus.run_req = 1; cyc(); bus.run_req = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("slow_mclk_%0d", i), bus.mclk_en, (i == 3 || i == 7) ? 1 : 0);
            cyc();
        end
        bus.slow = 0;
        bus.mem_wait = 1; #1;
        chk("wait_ph0_mclk", bus.mclk_en, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("wait_hold_%0d", i), bus.mclk_en, 0);
        end
        cyc();
        bus.mem_wait = 0; #1;
        chk("wait_release_mclk", bus.mclk_en, 1);
        chk("wait_release_wp", bus.wp, 1);
        bus.stop_req = 1; cyc(); bus.stop_req = 0;
        chk("wait_stop_halted", bus.halted, 1);
        cyc();

        // error halt mid-run
        bus.run_req = 1; cyc(); bus.run_req = 0;
        cyc(); cyc();
        bus.err = 1;
        cyc();
        chk("err_cycle_completes", bus.mclk_en, 1);
        cyc();
        chk("err_halted", bus.halted, 1);
        chk("err_halt_set", bus.err_halt, 1);
        bus.run_req = 1; bus.step_req = 1; cyc(); bus.run_req = 0; bus.step_req = 0;
        chk("err_req_ignored", bus.halted, 1);
        chk("err_halt_kept", bus.err_halt, 1);
        bus.err = 0;
        bus.run_req = 1; cyc(); bus.run_req = 0;
        chk("err_restart_running", bus.running, 1);
        chk("err_halt_cleared", bus.err_halt, 0);
        bus.stop_req = 1; cyc(); bus.stop_req = 0;
        cyc();
        chk("err_restart_stopped", bus.halted, 1);
        cyc();

        // RUN with STEP -> single step only
        bus.run_req = 1; bus.step_req = 1; cyc(); bus.run_req = 0; bus.step_req = 0;
        cyc();
        chk("runstep_mclk", bus.mclk_en, 1);
        cyc();
        chk("runstep_halted", bus.halted, 1);
        cyc();

        // RUN with STOP while halted -> stays halted
        bus.run_req = 1; bus.stop_req = 1; cyc(); bus.run_req = 0; bus.stop_req = 0;
        chk("runstop_halted", bus.halted, 1);
        cyc();
        chk("runstop_mclk", bus.mclk_en, 0);

        // step counter
        bus.cnt_load = 1; bus.cnt_val = 16'd5; cyc(); bus.cnt_load = 0;
`ifdef CADR_STEP_CNT_EN
        chk("cnt_loaded", bus.step_cnt, 5);
        pulses = 0;
        bus.run_req = 1; cyc(); bus.run_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mclk_en) pulses++;
            cyc();
        end
        chk("cnt_pulses", pulses, 5);
        chk("cnt_zero", bus.step_cnt, 0);
        chk("cnt_halted", bus.halted, 1);
        chk("cnt_err_halt", bus.err_halt, 0);
`else
        chk("cnt_disabled", bus.step_cnt, 0);
        pulses = 0;
`endif

        // asynchronous reset in the middle of a PH1 cycle
        bus.run_req = 1; cyc(); bus.run_req = 0;
        cyc();
        chk("arst_pre_mclk", bus.mclk_en, 1);
        r_n = 1'b0; #1;
        chk("arst_mclk", bus.mclk_en, 0);
        chk("arst_wp", bus.wp, 0);
        chk("arst_running", bus.running, 0);
        chk("arst_halted", bus.halted, 1);
        chk("arst_err_halt", bus.err_halt, 0);
        chk("arst_step_cnt", bus.step_cnt, 0);
        #3 r_n = 1'b1;
        cyc();
        chk("arst_stays_halted", bus.halted, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
